tile_map_sequencer: RTL and testbench

TILE_MAP_SEQUENCER -- requirements
Module: tile_map_sequencer

---
 rtl/tile_map_sequencer.sv | 174 +++++++++++++++++
 tb/tb_tile_map_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_sequencer.sv
// tile_map_sequencer
// ------------------
// Walks one screen of tiles in row-major order. For each tile it reads the
// tile index from a synchronous tile-map RAM, then hands the tile origin and
// index to an external tile drawer. Only one draw request is in flight at a time.
//
// Parameters:
//   SCREEN_COLS  tiles per screen row    (160 px / 8)
//   SCREEN_ROWS  tile rows per screen    (120 px / 8)
//
// Ports:
//   Clock       in   1   system clock, all state changes on the rising edge
//   Reset       in   1   synchronous, active-high reset
//   Start       in   1   begin one full-screen redraw (sampled only in IDLE)
//   ScrollCol   in   7   leftmost map column, captured when Start is accepted
//   MapAddress  out  11  tile-map RAM address {row[3:0], col[6:0]}
//   MapData     in   4   tile index, valid one cycle after MapAddress
//   TileX       out  8   pixel X of the tile origin
//   TileY       out  7   pixel Y of the tile origin
//   TileSel     out  4   tile index for the drawer
//   TileEnable  out  1   one-cycle draw request
//   TileDone    in   1   drawer idle flag (1 = idle, 0 = drawing)
//   Busy        out  1   high whenever the FSM is not in IDLE
//   FrameDone   out  1   one-cycle pulse after the last tile of a frame
//   DebugState  out  3   current FSM state encoding
//
// Handshake with the drawer: a request is made only while TileDone=1, and it is
// considered finished once TileDone has dropped low and then risen again.
// TileEnable is held for exactly one cycle per request.
//
// Build option: define SKIP_EMPTY_TILE_EN to skip tiles whose index is 0
// (no draw request is made for them). Undefined, tile 0 is drawn normally.

module tile_map_sequencer #(
    parameter int SCREEN_COLS = 20,
    parameter int SCREEN_ROWS = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [6:0]  ScrollCol,
    output logic [10:0] MapAddress,
    input  logic [3:0]  MapData,
    output logic [7:0]  TileX,
    output logic [6:0]  TileY,
    output logic [3:0]  TileSel,
    output logic        TileEnable,
    input  logic        TileDone,
    output logic        Busy,
    output logic        FrameDone,
    output logic [2:0]  DebugState
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LATCH     = 3'd2,
        ISSUE     = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5,
        ADVANCE   = 3'd6,
        FINISH    = 3'd7
    } state_t;

    localparam logic [4:0] LAST_COL = 5'(SCREEN_COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(SCREEN_ROWS - 1);

    state_t      state;
    state_t      next_state;
    logic [4:0]  col;
    logic [3:0]  row;
    logic [6:0]  scroll_q;
    logic [7:0]  tile_x;
    logic [6:0]  tile_y;
    logic [3:0]  tile_sel;
    logic [6:0]  map_col;

    // Map column wraps modulo 128; the carry never reaches the row field.
    assign map_col = 7'({2'b00, col}) + scroll_q;

    // State register and datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            scroll_q <= '0;
            tile_x   <= '0;
            tile_y   <= '0;
            tile_sel <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (Start) begin
                        scroll_q <= ScrollCol;
                        col      <= '0;
                        row      <= '0;
                    end
                end
                LATCH: begin
                    // The RAM read issued in FETCH is valid now.
                    tile_sel <= MapData;
                    tile_x   <= {col, 3'b000};
                    tile_y   <= {row, 3'b000};
                end
                ADVANCE: begin
                    if (col < LAST_COL) begin
                        col <= col + 5'd1;
                    end else begin
                        col <= '0;
                        if (row < LAST_ROW) begin
                            row <= row + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and outputs.
    always_comb begin
        next_state = state;
        TileEnable = 1'b0;
        FrameDone  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) next_state = FETCH;
            end
            FETCH: begin
                next_state = LATCH;
            end
            LATCH: begin
`ifdef SKIP_EMPTY_TILE_EN
                if (MapData == 4'd0) next_state = ADVANCE;
                else                 next_state = ISSUE;
`else
                next_state = ISSUE;
`endif
            end
            ISSUE: begin
                // Request only while the drawer reports idle.
                if (TileDone) begin
                    TileEnable = 1'b1;
                    next_state = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!TileDone) next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (TileDone) next_state = ADVANCE;
            end
            ADVANCE: begin
                if (col < LAST_COL || row < LAST_ROW) next_state = FETCH;
                else                                   next_state = FINISH;
            end
            FINISH: begin
                FrameDone  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign MapAddress = {row, map_col};
    assign TileX      = tile_x;
    assign TileY      = tile_y;
    assign TileSel    = tile_sel;
    assign Busy       = (state != IDLE);
    assign DebugState = state;

endmodule

// File: tb/tb_tile_map_sequencer.sv
// Testbench for tile_map_sequencer: RAM model, drawer model, and a scoreboard
// holding expected draw requests and expected FETCH addresses.
module tb_tile_map_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [6:0]  ScrollCol;
    logic [10:0] MapAddress;
    logic [3:0]  MapData;
    logic [7:0]  TileX;
    logic [6:0]  TileY;
    logic [3:0]  TileSel;
    logic        TileEnable;
    logic        TileDone;
    logic        Busy;
    logic        FrameDone;
    logic [2:0]  DebugState;

    tile_map_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .ScrollCol(ScrollCol),
        .MapAddress(MapAddress), .MapData(MapData), .TileX(TileX), .TileY(TileY),
        .TileSel(TileSel), .TileEnable(TileEnable), .TileDone(TileDone),
        .Busy(Busy), .FrameDone(FrameDone), .DebugState(DebugState)
    );

    // Clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [3:0]  map_mem [2048];
    logic [18:0] exp_q [$];
    logic [10:0] addr_q [$];
    int          frame_en = 0;
    int          exp_total = 0;
    int          fd_count = 0;
    logic [18:0] first_rec;
    logic [18:0] last_rec;
    bit          drawer_on = 1'b1;

    // Tile-map RAM: synchronous read, data follows the address by one cycle.
    initial begin : ram_model
        logic [10:0] a;
        MapData = 4'd0;
        forever begin
            @(negedge Clock);
            a = MapAddress;
            @(posedge Clock);
            #1 MapData = map_mem[a];
        end
    end

    // Drawer: drops TileDone one cycle after a request, busy for a few cycles.
    initial begin : drawer_model
        int b;
        forever begin
            @(negedge Clock);
            if (drawer_on && TileEnable) begin
                b = $urandom_range(1, 6);
                @(posedge Clock);
                #1 TileDone = 1'b0;
                repeat (b) @(posedge Clock);
                #1 TileDone = 1'b1;
            end
        end
    end

    // Scoreboard: compares draw requests and FETCH addresses as they appear.
    initial begin : monitor
        logic [18:0] got;
        logic [18:0] e;
        logic [10:0] ea;
        forever begin
            @(negedge Clock);
            if (TileEnable) begin
                frame_en++;
                got = {TileX, TileY, TileSel};
                if (frame_en == 1) first_rec = got;
                last_rec = got;
                check_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL tile_req: got %h expected no request", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) $display("FAIL tile_req: got %h expected %h", got, e);
                    else pass_cnt++;
                end
            end
            if (DebugState == 3'd1) begin
                check_cnt++;
                if (addr_q.size() == 0) begin
                    $display("FAIL map_addr: got %h expected no fetch", MapAddress);
                end else begin
                    ea = addr_q.pop_front();
                    if (MapAddress !== ea) $display("FAIL map_addr: got %h expected %h", MapAddress, ea);
                    else pass_cnt++;
                end
            end
            if (FrameDone) fd_count++;
        end
    end

    // Driver: fill expectations, then pulse Start (returns #1 after edge N).
    task automatic start_frame(input logic [6:0] sc);
        logic [6:0]  c7;
        logic [10:0] a;
        logic [3:0]  s;
        exp_q.delete();
        addr_q.delete();
        frame_en  = 0;
        exp_total = 0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                c7 = 7'(c) + sc;
                a  = {4'(r), c7};
                s  = map_mem[a];
                addr_q.push_back(a);
`ifdef SKIP_EMPTY_TILE_EN
                if (s != 4'd0) begin
                    exp_q.push_back({8'(c * 8), 7'(r * 8), s});
                    exp_total++;
                end
`else
                exp_q.push_back({8'(c * 8), 7'(r * 8), s});
                exp_total++;
`endif
            end
        end
        ScrollCol = sc;
        Start     = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int fd_before);
        int n = 0;
        while (fd_count == fd_before && n < 20000) begin
            @(negedge Clock);
            n++;
        end
        check_cnt++;
        if (fd_count == fd_before) $display("FAIL %s_timeout: got no FrameDone expected one within 20000 cycles", name);
        else pass_cnt++;
        repeat (3) @(negedge Clock);
        check_cnt++;
        if (fd_count !== fd_before + 1) $display("FAIL %s_framedone: got %0d expected %0d", name, fd_count - fd_before, 1);
        else pass_cnt++;
        check_cnt++;
        if (frame_en !== exp_total) $display("FAIL %s_req_count: got %0d expected %0d", name, frame_en, exp_total);
        else pass_cnt++;
        check_cnt++;
        if (exp_q.size() != 0 || addr_q.size() != 0) $display("FAIL %s_leftover: got %0d/%0d expected 0/0", name, exp_q.size(), addr_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else pass_cnt++;
        check_cnt++; if (TileEnable !== 1'b0) $display("FAIL reset_enable: got %b expected 0", TileEnable); else pass_cnt++;
        check_cnt++; if (FrameDone !== 1'b0) $display("FAIL reset_framedone: got %b expected 0", FrameDone); else pass_cnt++;
        check_cnt++; if (MapAddress !== 11'd0) $display("FAIL reset_addr: got %h expected 0", MapAddress); else pass_cnt++;
        check_cnt++; if ({TileX, TileY, TileSel} !== 19'd0) $display("FAIL reset_tile: got %h expected 0", {TileX, TileY, TileSel}); else pass_cnt++;
        check_cnt++; if (DebugState !== 3'd0) $display("FAIL reset_state: got %0d expected 0", DebugState); else pass_cnt++;
        @(posedge Clock);
        #1 Reset = 1'b0;
    endtask

    // Plain frame with no scroll; also checks first-request latency.
    task automatic test_full_frame();
        int fd0 = fd_count;
        logic [10:0] last_a = {4'd14, 7'd19};
        logic [18:0] exp_first;
        logic [18:0] exp_last;
        for (int i = 0; i < 2048; i++) map_mem[i] = 4'($urandom_range(0, 15));
        exp_first = {8'd0, 7'd0, map_mem[0]};
        exp_last  = {8'd152, 7'd112, map_mem[last_a]};
        start_frame(7'd0);
        @(negedge Clock);
        check_cnt++; if (TileEnable !== 1'b0 || DebugState !== 3'd1) $display("FAIL latency_n0: got en=%b st=%0d expected en=0 st=1", TileEnable, DebugState); else pass_cnt++;
        @(negedge Clock);
        check_cnt++; if (TileEnable !== 1'b0 || DebugState !== 3'd2) $display("FAIL latency_n1: got en=%b st=%0d expected en=0 st=2", TileEnable, DebugState); else pass_cnt++;
        @(negedge Clock);
        check_cnt++; if (TileEnable !== 1'b1) $display("FAIL latency_n2: got en=%b expected 1", TileEnable); else pass_cnt++;
        wait_frame("full", fd0);
        check_cnt++; if (first_rec !== exp_first) $display("FAIL full_first: got %h expected %h", first_rec, exp_first); else pass_cnt++;
        check_cnt++; if (last_rec !== exp_last) $display("FAIL full_last: got %h expected %h", last_rec, exp_last); else pass_cnt++;
    endtask

    // Scrolled window crossing the 127 -> 0 map column boundary.
    task automatic test_scroll_wrap();
        int fd0 = fd_count;
        for (int i = 0; i < 2048; i++) map_mem[i] = 4'(i % 16);
        start_frame(7'd120);
        wait_frame("wrap", fd0);
    endtask

    // Drawer holds TileDone low while the FSM waits in ISSUE.
    task automatic test_done_hold();
        int fd0 = fd_count;
        int n = 0;
        int bad = 0;
        logic [18:0] held;
        logic [10:0] a0 = {4'd0, 7'd5};
        logic [18:0] exp_held;
        for (int i = 0; i < 2048; i++) map_mem[i] = 4'($urandom_range(0, 15));
        exp_held = {8'd0, 7'd0, map_mem[a0]};
        drawer_on = 1'b0;
        TileDone  = 1'b0;
        start_frame(7'd5);
        while (DebugState !== 3'd3 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check_cnt++; if (DebugState !== 3'd3) $display("FAIL hold_reach_issue: got %0d expected 3", DebugState); else pass_cnt++;
        held = {TileX, TileY, TileSel};
        check_cnt++; if (held !== exp_held) $display("FAIL hold_tile: got %h expected %h", held, exp_held); else pass_cnt++;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (TileEnable !== 1'b0 || {TileX, TileY, TileSel} !== held || DebugState !== 3'd3) bad++;
        end
        check_cnt++; if (bad != 0) $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); else pass_cnt++;
        @(posedge Clock);
        #1 TileDone = 1'b1;
        @(negedge Clock);
        check_cnt++; if (TileEnable !== 1'b1) $display("FAIL hold_release: got %b expected 1", TileEnable); else pass_cnt++;
        @(posedge Clock);
        #1 TileDone = 1'b0;
        repeat (3) @(posedge Clock);
        #1 TileDone = 1'b1;
        drawer_on = 1'b1;
        wait_frame("hold", fd0);
    endtask

    // Reset during WAIT_DONE of tile 37, then a clean restart.
    task automatic test_reset_mid();
        int fd0 = fd_count;
        int n = 0;
        for (int i = 0; i < 2048; i++) map_mem[i] = 4'($urandom_range(0, 15));
        start_frame(7'd33);
        while (!(frame_en == 38 && DebugState == 3'd5) && n < 5000) begin
            @(negedge Clock);
            n++;
        end
        check_cnt++; if (frame_en != 38 || DebugState !== 3'd5) $display("FAIL mid_reach: got req=%0d st=%0d expected 38/5", frame_en, DebugState); else pass_cnt++;
        Reset = 1'b1;
        @(posedge Clock);
        #1 Reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(negedge Clock);
        check_cnt++; if (DebugState !== 3'd0 || Busy !== 1'b0 || TileEnable !== 1'b0) $display("FAIL mid_reset: got st=%0d busy=%b en=%b expected 0/0/0", DebugState, Busy, TileEnable); else pass_cnt++;
        repeat (20) @(negedge Clock);
        check_cnt++; if (fd_count !== fd0) $display("FAIL mid_no_framedone: got %0d expected %0d", fd_count, fd0); else pass_cnt++;
        start_frame(7'd0);
        wait_frame("restart", fd0);
        check_cnt++; if (first_rec[18:4] !== 15'd0) $display("FAIL restart_first: got %h expected 0", first_rec[18:4]); else pass_cnt++;
    endtask

    // Start re-pulsed during a frame must be ignored.
    task automatic test_back_to_back();
        int fd0 = fd_count;
        for (int i = 0; i < 2048; i++) map_mem[i] = 4'($urandom_range(0, 15));
        start_frame(7'd64);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(50, 400)) @(posedge Clock);
            #1;
            ScrollCol = 7'($urandom_range(0, 127));
            Start     = 1'b1;
            @(posedge Clock);
            #1 Start = 1'b0;
        end
        wait_frame("restart_ignored", fd0);
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        ScrollCol = 7'd0;
        TileDone  = 1'b1;
        for (int i = 0; i < 2048; i++) map_mem[i] = 4'd0;
        test_reset();
        test_full_frame();
        test_scroll_wrap();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
